// File: rtl/alu_pkg.sv
// Shared types for the ALU function issuer: unit-select codes, requester id, FSM states.
package alu_pkg;

   localparam logic [1:0] FUN_ARITH = 2'b00;
   localparam logic [1:0] FUN_LOGIC = 2'b01;
   localparam logic [1:0] FUN_CMP   = 2'b10;
   localparam logic [1:0] FUN_SHIFT = 2'b11;

   typedef logic [1:0] req_id_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   function automatic logic [1:0] fun_of(input req_id_t id);
      unique case (id)
         2'd0: fun_of = FUN_ARITH;
         2'd1: fun_of = FUN_LOGIC;
         2'd2: fun_of = FUN_CMP;
         2'd3: fun_of = FUN_SHIFT;
      endcase
   endfunction

endpackage

// File: rtl/alu_issue_arbiter.sv
// Combinational 4-way grant; round-robin from ptr_i+1 with ALU_ISSUER_ROUND_ROBIN_EN,
// otherwise fixed priority with the lowest index winning.
module alu_issue_arbiter
   import alu_pkg::*;
(
   input  logic [3:0] req_i,
`ifdef ALU_ISSUER_ROUND_ROBIN_EN
   input  req_id_t    ptr_i,
`endif
   output logic [3:0] gnt_o,
   output req_id_t    idx_o,
   output logic       any_o
);

`ifdef ALU_ISSUER_ROUND_ROBIN_EN
   req_id_t cand;

   // Scan from farthest to nearest so the slot right after ptr_i wins.
   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      cand  = '0;
      for (int k = 3; k >= 0; k--) begin
         cand = ptr_i + req_id_t'(k + 1);
         if (req_i[cand]) begin
            idx_o = cand;
            any_o = 1'b1;
         end
      end
   end
`else
   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      for (int k = 3; k >= 0; k--) begin
         if (req_i[k]) begin
            idx_o = req_id_t'(k);
            any_o = 1'b1;
         end
      end
   end
`endif

   assign gnt_o = any_o ? (4'b0001 << idx_o) : 4'b0000;

endmodule

// File: rtl/alu_fun_issuer.sv
// Arbitrates four ALU request classes, issues one op at a time and returns the result.
// Grant policy selected by ALU_ISSUER_ROUND_ROBIN_EN (default: fixed priority).
module alu_fun_issuer
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [3:0]              req_valid_i,
   output logic [3:0]              req_ready_o,
   input  logic [4*DATA_WIDTH-1:0] req_a_i,
   input  logic [4*DATA_WIDTH-1:0] req_b_i,
   input  logic [7:0]              req_sel_i,
   output logic [1:0]              alu_fun_o,
   output logic [1:0]              alu_sel_o,
   output logic [DATA_WIDTH-1:0]   alu_a_o,
   output logic [DATA_WIDTH-1:0]   alu_b_o,
   output logic                    alu_valid_o,
   input  logic [DATA_WIDTH-1:0]   alu_result_i,
   input  logic                    alu_res_valid_i,
   output logic                    rsp_valid_o,
   output logic [1:0]              rsp_id_o,
   output logic [DATA_WIDTH-1:0]   rsp_data_o,
   input  logic                    rsp_ready_i
);

   state_t                  state_q, state_d;
   logic [1:0]              fun_q, fun_d;
   logic [1:0]              sel_q, sel_d;
   logic [DATA_WIDTH-1:0]   a_q, a_d;
   logic [DATA_WIDTH-1:0]   b_q, b_d;
   req_id_t                 id_q, id_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic [3:0]              gnt;
   req_id_t                 gidx;
   logic                    gany;

`ifdef ALU_ISSUER_ROUND_ROBIN_EN
   req_id_t                 ptr_q, ptr_d;
`endif

   alu_issue_arbiter u_arb (
      .req_i (req_valid_i),
`ifdef ALU_ISSUER_ROUND_ROBIN_EN
      .ptr_i (ptr_q),
`endif
      .gnt_o (gnt),
      .idx_o (gidx),
      .any_o (gany)
   );

   always_comb begin
      state_d = state_q;
      fun_d   = fun_q;
      sel_d   = sel_q;
      a_d     = a_q;
      b_d     = b_q;
      id_d    = id_q;
      data_d  = data_q;
`ifdef ALU_ISSUER_ROUND_ROBIN_EN
      ptr_d   = ptr_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (gany) begin
               state_d = S_ISSUE;
               fun_d   = fun_of(gidx);
               sel_d   = req_sel_i[{gidx, 1'b0} +: 2];
               a_d     = req_a_i[gidx * DATA_WIDTH +: DATA_WIDTH];
               b_d     = req_b_i[gidx * DATA_WIDTH +: DATA_WIDTH];
               id_d    = gidx;
`ifdef ALU_ISSUER_ROUND_ROBIN_EN
               ptr_d   = gidx;
`endif
            end
         end
         // A zero-latency ALU may answer in the issue cycle itself.
         S_ISSUE: begin
            if (alu_res_valid_i) begin
               data_d  = alu_result_i;
               state_d = S_RESP;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (alu_res_valid_i) begin
               data_d  = alu_result_i;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready_i) state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         fun_q   <= FUN_ARITH;
         sel_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         id_q    <= '0;
         data_q  <= '0;
`ifdef ALU_ISSUER_ROUND_ROBIN_EN
         ptr_q   <= 2'd3;
`endif
      end else begin
         state_q <= state_d;
         fun_q   <= fun_d;
         sel_q   <= sel_d;
         a_q     <= a_d;
         b_q     <= b_d;
         id_q    <= id_d;
         data_q  <= data_d;
`ifdef ALU_ISSUER_ROUND_ROBIN_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   // Ready is combinational from the grant, so gate it during reset.
   assign req_ready_o = (state_q == S_IDLE && !rst_i) ? gnt : 4'b0000;
   assign alu_fun_o   = fun_q;
   assign alu_sel_o   = sel_q;
   assign alu_a_o     = a_q;
   assign alu_b_o     = b_q;
   assign alu_valid_o = (state_q == S_ISSUE);
   assign rsp_valid_o = (state_q == S_RESP);
   assign rsp_id_o    = id_q;
   assign rsp_data_o  = data_q;

endmodule

// File: tb/tb_alu_fun_issuer.sv
// Self-checking bench for alu_fun_issuer; honours ALU_ISSUER_ROUND_ROBIN_EN.
module tb_alu_fun_issuer;

   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [3:0]     req_valid = '0;
   logic [3:0]     req_ready;
   logic [4*W-1:0] req_a = '0;
   logic [4*W-1:0] req_b = '0;
   logic [7:0]     req_sel = '0;
   logic [1:0]     alu_fun, alu_sel;
   logic [W-1:0]   alu_a, alu_b;
   logic           alu_valid;
   logic [W-1:0]   alu_result = '0;
   logic           alu_res_valid = 1'b0;
   logic           rsp_valid;
   logic [1:0]     rsp_id;
   logic [W-1:0]   rsp_data;
   logic           rsp_ready = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   alu_fun_issuer #(.DATA_WIDTH(W)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .req_valid_i     (req_valid),
      .req_ready_o     (req_ready),
      .req_a_i         (req_a),
      .req_b_i         (req_b),
      .req_sel_i       (req_sel),
      .alu_fun_o       (alu_fun),
      .alu_sel_o       (alu_sel),
      .alu_a_o         (alu_a),
      .alu_b_o         (alu_b),
      .alu_valid_o     (alu_valid),
      .alu_result_i    (alu_result),
      .alu_res_valid_i (alu_res_valid),
      .rsp_valid_o     (rsp_valid),
      .rsp_id_o        (rsp_id),
      .rsp_data_o      (rsp_data),
      .rsp_ready_i     (rsp_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: where the one in-flight op is in its life.
   localparam int P_FREE = 0, P_ISSUE = 1, P_WAIT = 2, P_RESP = 3;
   int           ph = P_FREE;
   logic [1:0]   m_last = 2'd3;
   logic [1:0]   m_id = '0, m_fun = '0, m_sel = '0;
   logic [W-1:0] m_a = '0, m_b = '0, m_data = '0;

   // Rotate the request vector so the search origin sits at bit 0.
   function automatic logic [1:0] pick(input logic [3:0] v);
      logic [1:0] base;
      logic [7:0] dbl;
      logic [3:0] rot;
      logic [1:0] p;
`ifdef ALU_ISSUER_ROUND_ROBIN_EN
      base = m_last + 2'd1;
`else
      base = 2'd0;
`endif
      dbl = {v, v};
      rot = dbl[base +: 4];
      p   = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (rot[i]) p = 2'(i);
      return base + p;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ph <= P_FREE; m_last <= 2'd3; m_id <= '0; m_fun <= '0;
         m_sel <= '0; m_a <= '0; m_b <= '0; m_data <= '0;
      end else begin
         case (ph)
            P_FREE: if (req_valid != 4'b0) begin
               m_id  <= pick(req_valid);
               m_fun <= pick(req_valid);
               m_sel <= req_sel[2*pick(req_valid) +: 2];
               m_a   <= req_a[W*pick(req_valid) +: W];
               m_b   <= req_b[W*pick(req_valid) +: W];
`ifdef ALU_ISSUER_ROUND_ROBIN_EN
               m_last <= pick(req_valid);
`endif
               ph <= P_ISSUE;
            end
            P_ISSUE: if (alu_res_valid) begin
               m_data <= alu_result; ph <= P_RESP;
            end else ph <= P_WAIT;
            P_WAIT: if (alu_res_valid) begin
               m_data <= alu_result; ph <= P_RESP;
            end
            default: if (rsp_ready) ph <= P_FREE;
         endcase
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_ready", req_ready, 0);
         chk("rst_alu_valid", alu_valid, 0);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_fun", alu_fun, 0);
         chk("rst_a", alu_a, 0);
      end else begin
         chk("req_ready", req_ready,
             (ph == P_FREE && req_valid != 0) ? (4'b0001 << pick(req_valid)) : 4'b0);
         chk("alu_valid", alu_valid, ph == P_ISSUE);
         chk("rsp_valid", rsp_valid, ph == P_RESP);
         chk("alu_fun", alu_fun, m_fun);
         chk("alu_sel", alu_sel, m_sel);
         chk("alu_a", alu_a, m_a);
         chk("alu_b", alu_b, m_b);
         if (ph == P_RESP) begin
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_data", rsp_data, m_data);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Starts in IDLE just after an edge; ends back in IDLE just after an edge.
   task automatic run_txn(input logic [3:0] v, input int lat, input int hold,
                          input logic [W-1:0] res, input logic [1:0] exp_id,
                          input logic [W-1:0] exp_a);
      req_valid = v;
      step();
      chk("lit_issue_strobe", alu_valid, 1);
      chk("lit_issue_fun", alu_fun, exp_id);
      chk("lit_issue_a", alu_a, exp_a);
      if (lat > 0) begin
         repeat (lat) step();
         chk("lit_wait_no_strobe", alu_valid, 0);
      end
      alu_res_valid = 1'b1;
      alu_result    = res;
      step();
      alu_res_valid = 1'b0;
      chk("lit_rsp_valid", rsp_valid, 1);
      chk("lit_rsp_id", rsp_id, exp_id);
      chk("lit_rsp_data", rsp_data, res);
      for (int h = 0; h < hold; h++) begin
         alu_res_valid = 1'b1;
         alu_result    = ~res;
         step();
      end
      alu_res_valid = 1'b0;
      if (hold > 0) begin
         chk("lit_hold_rsp_valid", rsp_valid, 1);
         chk("lit_hold_rsp_data", rsp_data, res);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int ord[5];
`ifdef ALU_ISSUER_ROUND_ROBIN_EN
      ord = '{0, 1, 2, 3, 0};
`else
      ord = '{0, 0, 0, 0, 0};
`endif
      // Requests during reset must not be accepted.
      rst = 1'b1;
      req_valid = 4'hF;
      repeat (2) step();
      chk("lit_rst_ready", req_ready, 0);
      chk("lit_rst_fun", alu_fun, 0);
      rst = 1'b0;
      req_valid = 4'h0;
      step();

      // Single arith op, zero-latency ALU.
      req_a = {48'h0, 16'h0003};
      req_b = {48'h0, 16'h0004};
      req_sel = 8'h00;
      run_txn(4'b0001, 0, 0, 16'h0007, 2'd0, 16'h0003);
      req_valid = 4'b0;
      chk("lit_hold_a", alu_a, 16'h0003);
      chk("lit_hold_b", alu_b, 16'h0004);

      // Slow ALU: result 10 cycles after issue.
      req_a = {16'h0, 16'h1234, 32'h0};
      req_b = {16'h0, 16'h0042, 32'h0};
      req_sel = 8'b00_10_00_00;
      run_txn(4'b0100, 10, 0, 16'h0001, 2'd2, 16'h1234);
      req_valid = 4'b0;

      // Response back-pressure with spurious results while waiting.
      req_a = {16'h00F0, 48'h0};
      req_b = {16'h0004, 48'h0};
      req_sel = 8'b01_00_00_00;
      run_txn(4'b1000, 1, 5, 16'h0F00, 2'd3, 16'h00F0);
      req_valid = 4'b0;

      // All requesters held active.
      req_a = {16'h0D03, 16'h0C02, 16'h0B01, 16'h0A00};
      req_b = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
      req_sel = 8'b11_10_01_00;
      for (int i = 0; i < 5; i++)
         run_txn(4'b1111, 0, 0, 16'h5000 + 16'(i), 2'(ord[i]),
                 16'h0A00 + 16'(ord[i]) * 16'h0101);
      req_valid = 4'b0;

      // Reset while waiting on the ALU.
      req_valid = 4'b0010;
      step();
      req_valid = 4'b0;
      step();
      step();
      req_valid = 4'hF;
      rst = 1'b1;
      #1;
      chk("lit_async_alu_valid", alu_valid, 0);
      chk("lit_async_rsp_valid", rsp_valid, 0);
      chk("lit_async_fun", alu_fun, 0);
      chk("lit_async_a", alu_a, 0);
      chk("lit_async_ready", req_ready, 0);
      alu_res_valid = 1'b1;
      alu_result = 16'hDEAD;
      step();
      rst = 1'b0;
      req_valid = 4'b0;
      step();
      step();
      chk("lit_late_result_ignored", rsp_valid, 0);
      alu_res_valid = 1'b0;
      run_txn(4'b1111, 0, 0, 16'h0ABC, 2'd0, 16'h0A00);
      req_valid = 4'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_fun_issuer.md
ALU_FUN_ISSUER -- requirements
Module: alu_fun_issuer

Interface
REQ-001 Parameter: DATA_WIDTH, default 16, operand/result width.
REQ-002 CLK  in  1  single clock; all state on rising edge.
REQ-003 RST  in  1  asynchronous, active-high reset.
REQ-004 REQ_VALID  in  4  per-class request; index 0 arith, 1 logic, 2 cmp, 3 shift.
REQ-005 REQ_READY  out  4  one-hot accept, at most one bit high.
REQ-006 REQ_A  in  4*DATA_WIDTH  packed operand A, slice i belongs to requester i.
REQ-007 REQ_B  in  4*DATA_WIDTH  packed operand B, slice i.
REQ-008 REQ_SEL  in  8  packed 2-bit sub-op, bits [2i+1:2i].
REQ-009 ALU_FUN  out  2  encoded unit select toward ALU decoder.
REQ-010 ALU_SEL  out  2  sub-op toward ALU.
REQ-011 ALU_A, ALU_B  out  DATA_WIDTH each  registered operands.
REQ-012 ALU_VALID  out  1  one-cycle issue strobe.
REQ-013 ALU_RESULT  in  DATA_WIDTH; ALU_RES_VALID  in  1  ALU result and qualifier.
REQ-014 RSP_VALID  out  1; RSP_ID  out  2; RSP_DATA  out  DATA_WIDTH; RSP_READY  in  1  response channel.

Function
REQ-015 FSM states IDLE, ISSUE, WAIT, RESP; only IDLE accepts requests.
REQ-016 IDLE: REQ_READY[g] SHALL be high combinationally for the granted index g of nonzero REQ_VALID; transfer = REQ_VALID[g] & REQ_READY[g]; all REQ_READY low outside IDLE.
REQ-017 On transfer, ALU_A/ALU_B/ALU_SEL latch slice g, ALU_FUN latches g encoded (0->2'b00, 1->2'b01, 2->2'b10, 3->2'b11), ID register latches g; next state ISSUE.
REQ-018 ISSUE: ALU_VALID=1 for exactly one cycle; next state WAIT.
REQ-019 WAIT: hold until ALU_RES_VALID=1; capture ALU_RESULT into RSP_DATA; next state RESP. ALU_RES_VALID in the ISSUE cycle itself SHALL also be accepted (zero-latency ALU) and move directly to RESP.
REQ-020 ALU_RES_VALID in IDLE or RESP SHALL be ignored.
REQ-021 RESP: RSP_VALID=1, RSP_ID=g, RSP_DATA stable until RSP_READY=1; that cycle returns to IDLE; new grant possible the following cycle.
REQ-022 ALU_FUN, ALU_SEL, ALU_A, ALU_B hold their value until the next transfer.
REQ-023 Minimum request-to-response: transfer cycle T, ALU_VALID at T+1, RSP_VALID at T+2 if ALU_RES_VALID at T+1.

Reset
REQ-024 RST high SHALL immediately force IDLE, all outputs zero (ALU_FUN=2'b00, REQ_READY=0, ALU_VALID=0, RSP_VALID=0), grant pointer = 3, regardless of state; an in-flight operation is dropped, later ALU_RES_VALID ignored.

Configuration
REQ-025 Macro ALU_ISSUER_ROUND_ROBIN_EN defined: grant search starts at (last granted + 1) mod 4; pointer updates on each transfer.
REQ-026 Macro undefined: fixed priority, lowest index wins; no pointer register.

Structure
REQ-027 Shared package alu_pkg: ALU_FUN encoding constants (FUN_ARITH, FUN_LOGIC, FUN_CMP, FUN_SHIFT), 2-bit requester-id typedef, FSM state enum.
REQ-028 One sub-module alu_issue_arbiter: REQ_VALID + pointer -> one-hot grant and encoded index; purely combinational, macro-controlled.

Verification
REQ-029 Single arith request A=16'h0003, B=16'h0004, SEL=00; ALU model returns 16'h0007 at T+1 -> ALU_FUN=00, ALU_VALID at T+1, RSP_ID=0, RSP_DATA=16'h0007 at T+2.
REQ-030 REQ_VALID=4'b1111 held, RSP_READY=1 -> round-robin grant order 0,1,2,3,0; macro off -> order 0,0,0.
REQ-031 RSP_READY low 5 cycles in RESP -> RSP_VALID/RSP_DATA stable, REQ_READY=0, spurious ALU_RES_VALID ignored.
REQ-032 ALU_RES_VALID delayed 10 cycles in WAIT -> ALU_VALID single pulse, RSP follows one cycle after result.
REQ-033 RST asserted in WAIT -> outputs zero same cycle, IDLE after release, next grant index 0, late ALU_RES_VALID produces no RSP_VALID.
